// File: rtl/ula_multiciclo.sv
// Registered MIPS ALU with start/done handshake: single-cycle logic/arith/shift ops
// plus iterative unsigned MULTU (shift-add) and DIVU (restoring), HI/LO style results.
module ula_multiciclo #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inicio,
  input  logic [3:0]       ctrlULA,
  input  logic [WIDTH-1:0] entradaA,
  input  logic [WIDTH-1:0] entradaB,
  output logic [WIDTH-1:0] saida,
  output logic [WIDTH-1:0] saidaHi,
  output logic             zero,
  output logic             overflow,
  output logic             divZero,
  output logic             ocupado,
  output logic             pronto
);
  localparam logic [1:0] OCIOSO = 2'd0, CALC = 2'd1, FIM = 2'd2;
  localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2, OP_MULTU = 4'd3,
                         OP_DIVU = 4'd4, OP_SUB = 4'd6, OP_SLT = 4'd7, OP_SLTU = 4'd8,
                         OP_SLL = 4'd9, OP_SRL = 4'd10, OP_SRA = 4'd11, OP_NOR = 4'd12;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]         state_q, state_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   saida_q, saida_d, hi_q, hi_d;
  logic               zero_q, zero_d, ov_q, ov_d, dz_q, dz_d;

  logic [WIDTH-1:0]   alu_res, sum, dif;
  logic               alu_ov;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     mul_sum, trial;
  logic [2*WIDTH-1:0] step;

  always_comb begin
    sum     = entradaA + entradaB;
    dif     = entradaA - entradaB;
    shamt   = entradaB[SHAMT_W-1:0];
    alu_res = '0;
    alu_ov  = 1'b0;
    case (ctrlULA)
      OP_AND:  alu_res = entradaA & entradaB;
      OP_OR:   alu_res = entradaA | entradaB;
      OP_NOR:  alu_res = ~(entradaA | entradaB);
      OP_ADD: begin
        alu_res = sum;
        alu_ov  = (entradaA[WIDTH-1] == entradaB[WIDTH-1]) && (sum[WIDTH-1] != entradaA[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif;
        alu_ov  = (entradaA[WIDTH-1] != entradaB[WIDTH-1]) && (dif[WIDTH-1] != entradaA[WIDTH-1]);
      end
      OP_SLT:  alu_res[0] = $signed(entradaA) < $signed(entradaB);
      OP_SLTU: alu_res[0] = entradaA < entradaB;
      OP_SLL:  alu_res = entradaA << shamt;
      OP_SRL:  alu_res = entradaA >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(entradaA) >>> shamt);
      default: ;
    endcase
  end

  // One iteration: acc = {HI, LO}. MULTU adds A into HI when LO[0] is set, then shifts right;
  // DIVU shifts the dividend MSB into the remainder and keeps the subtraction if it didn't borrow.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    trial   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    if (!is_div_q)   step = {mul_sum, acc_q[WIDTH-1:1]};
    else if (trial[WIDTH]) step = {acc_q[2*WIDTH-2:0], 1'b0};
    else             step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    saida_d  = saida_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    ov_d     = ov_q;
    dz_d     = dz_q;
    case (state_q)
      OCIOSO: if (inicio) begin
        if (ctrlULA == OP_MULTU || (ctrlULA == OP_DIVU && entradaB != '0)) begin
          is_div_d = (ctrlULA == OP_DIVU);
          opnd_d   = (ctrlULA == OP_DIVU) ? entradaB : entradaA;
          acc_d    = {{WIDTH{1'b0}}, (ctrlULA == OP_DIVU) ? entradaA : entradaB};
          cnt_d    = CNT_W'(WIDTH);
          state_d  = CALC;
        end else if (ctrlULA == OP_DIVU) begin
          saida_d = '1;
          hi_d    = entradaA;
          zero_d  = 1'b0;
          ov_d    = 1'b0;
          dz_d    = 1'b1;
          state_d = FIM;
        end else begin
          saida_d = alu_res;
          hi_d    = '0;
          zero_d  = (alu_res == '0);
          ov_d    = alu_ov;
          dz_d    = 1'b0;
          state_d = FIM;
        end
      end
      CALC: begin
        acc_d = step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          saida_d = step[WIDTH-1:0];
          hi_d    = step[2*WIDTH-1:WIDTH];
          zero_d  = (step[WIDTH-1:0] == '0);
          ov_d    = 1'b0;
          dz_d    = 1'b0;
          state_d = FIM;
        end
      end
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= OCIOSO;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      saida_q  <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
      ov_q     <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      saida_q  <= saida_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      ov_q     <= ov_d;
      dz_q     <= dz_d;
    end
  end

  assign saida    = saida_q;
  assign saidaHi  = hi_q;
  assign zero     = zero_q;
  assign overflow = ov_q;
  assign divZero  = dz_q;
  assign ocupado  = (state_q == CALC);
  assign pronto   = (state_q == FIM);
endmodule

// File: tb/tb_ula_multiciclo.sv
// Randomized bench for ula_multiciclo: an arithmetic reference model predicts every completion
// (value and cycle) and a per-cycle compare process checks handshake and held outputs.
module tb_ula_multiciclo;
  localparam int W = 32;

  logic          clock = 1'b0, reset_n = 1'b0, inicio = 1'b0;
  logic [3:0]    ctrl = '0;
  logic [W-1:0]  a = '0, b = '0;
  logic [W-1:0]  saida, saidaHi;
  logic          zero, overflow, divZero, ocupado, pronto;

  logic          inicio8 = 1'b0;
  logic [3:0]    ctrl8 = '0;
  logic [7:0]    a8 = '0, b8 = '0, saida8, hi8;
  logic          zero8, ov8, dz8, ocup8, pronto8;

  ula_multiciclo #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .inicio(inicio), .ctrlULA(ctrl),
    .entradaA(a), .entradaB(b), .saida(saida), .saidaHi(saidaHi), .zero(zero),
    .overflow(overflow), .divZero(divZero), .ocupado(ocupado), .pronto(pronto));

  ula_multiciclo #(.WIDTH(8), .SHAMT_W(3)) dut8 (
    .clock(clock), .reset_n(reset_n), .inicio(inicio8), .ctrlULA(ctrl8),
    .entradaA(a8), .entradaB(b8), .saida(saida8), .saidaHi(hi8), .zero(zero8),
    .overflow(ov8), .divZero(dz8), .ocupado(ocup8), .pronto(pronto8));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int acc; int due; bit multi;
    logic [31:0] lo, hi; bit z, ov, dz;
  } exp_t;

  exp_t        q[$];
  logic [31:0] l_lo = '0, l_hi = '0;
  bit          l_z = 1'b1, l_ov = 1'b0, l_dz = 1'b0;
  int          total = 0, bad = 0, next_ok = 0, last_acc = 0;
  bit          started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values, w bits wide.
  function automatic exp_t model(input logic [3:0] op, input logic [63:0] xi,
                                 input logic [63:0] yi, input int w);
    exp_t r;
    logic [63:0] mask, x, y, v;
    longint sx, sy, s, mx;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    x = xi & mask;
    y = yi & mask;
    sx = x[w-1] ? $signed(x | ~mask) : $signed(x);
    sy = y[w-1] ? $signed(y | ~mask) : $signed(y);
    mx = (64'sd1 <<< (w - 1)) - 1;
    sh = int'(y[4:0]);
    r = '{default: 0};
    v = '0;
    case (op)
      4'd0:  v = x & y;
      4'd1:  v = x | y;
      4'd2:  begin v = x + y; s = sx + sy; r.ov = (s > mx) || (s < -mx - 1); end
      4'd6:  begin v = x - y; s = sx - sy; r.ov = (s > mx) || (s < -mx - 1); end
      4'd12: v = ~(x | y);
      4'd7:  v = (sx < sy) ? 64'd1 : 64'd0;
      4'd8:  v = (x < y) ? 64'd1 : 64'd0;
      4'd9:  v = x << sh;
      4'd10: v = x >> sh;
      4'd11: v = sx >>> sh;
      4'd3:  begin v = x * y; r.hi = 32'((v >> w) & mask); r.multi = 1'b1; end
      4'd4:  if (y == 0) begin v = mask; r.hi = x[31:0]; r.dz = 1'b1; end
             else begin v = x / y; r.hi = 32'(x % y); r.multi = 1'b1; end
      default: v = '0;
    endcase
    v &= mask;
    r.lo = v[31:0];
    r.z  = (v == 0);
    return r;
  endfunction

  // Per-cycle check: pronto/ocupado timing against the predicted schedule, outputs against
  // the last completion (which updates in the very cycle pronto is due).
  initial begin
    bit ep, eo;
    forever begin
      @(negedge clock);
      if (started) begin
        ep = (q.size() > 0) && (q[0].due == cyc);
        eo = (q.size() > 0) && q[0].multi && (cyc >= q[0].acc) && (cyc < q[0].due);
        chk("pronto", pronto, ep);
        chk("ocupado", ocupado, eo);
        if (ep) begin
          l_lo = q[0].lo; l_hi = q[0].hi; l_z = q[0].z; l_ov = q[0].ov; l_dz = q[0].dz;
          void'(q.pop_front());
        end
        chk("saida", saida, l_lo);
        chk("saidaHi", saidaHi, l_hi);
        chk("zero", zero, l_z);
        chk("overflow", overflow, l_ov);
        chk("divZero", divZero, l_dz);
      end
    end
  end

  // Called at a negedge; the request is sampled at the following posedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit keep);
    exp_t e;
    while (cyc + 1 < next_ok) @(negedge clock);
    ctrl = op; a = x; b = y; inicio = 1'b1;
    e = model(op, x, y, W);
    e.acc = cyc + 1;
    e.due = e.multi ? cyc + 1 + W : cyc + 1;
    q.push_back(e);
    last_acc = e.acc;
    next_ok = e.due + 2;
    @(negedge clock);
    if (!keep) inicio = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 100) begin @(negedge clock); t++; end
    total++;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d completions still pending, want 0", q.size());
      q.delete();
    end
    @(negedge clock);
  endtask

  task automatic do_reset(input string name);
    #2 reset_n = 1'b0;
    q.delete();
    next_ok = 0;
    l_lo = '0; l_hi = '0; l_z = 1'b1; l_ov = 1'b0; l_dz = 1'b0;
    #1;
    chk({name, "_saida"}, saida, 32'h0);
    chk({name, "_hi"}, saidaHi, 32'h0);
    chk({name, "_zero"}, zero, 1'b1);
    chk({name, "_ovdz"}, {overflow, divZero, ocupado, pronto}, 4'h0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int st, n;
    e = model(op, {56'd0, x}, {56'd0, y}, 8);
    ctrl8 = op; a8 = x; b8 = y; inicio8 = 1'b1;
    st = cyc + 1;
    @(negedge clock);
    inicio8 = 1'b0;
    n = 0;
    while (!pronto8 && n < 40) begin @(negedge clock); n++; end
    chk("w8_latency", 64'(cyc - st), 64'(e.multi ? 8 : 0));
    chk("w8_saida", saida8, e.lo[7:0]);
    chk("w8_hi", hi8, e.hi[7:0]);
    chk("w8_dz", dz8, e.dz);
    repeat (2) @(negedge clock);
  endtask

  function automatic logic [31:0] rval();
    logic [31:0] sp[5];
    sp = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    if ($urandom_range(3) == 0) return sp[$urandom_range(4)];
    return $urandom();
  endfunction

  initial begin
    exp_t m;
    logic [3:0] ops[16];
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd12, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11,
            4'd3, 4'd4, 4'd5, 4'd13, 4'd14, 4'd15};

    // Hand-computed values pinning the model itself.
    m = model(4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32);
    chk("pin_mul", {m.hi, m.lo}, 64'hFFFFFFFE_00000001);
    m = model(4'd4, 100, 7, 32);      chk("pin_div", {m.hi, m.lo}, {32'd2, 32'd14});
    m = model(4'd2, 32'h7FFFFFFF, 1, 32); chk("pin_add", {m.ov, m.z, m.lo}, {2'b10, 32'h80000000});
    m = model(4'd6, 5, 5, 32);        chk("pin_sub", {m.ov, m.z, m.lo}, {2'b01, 32'h0});
    m = model(4'd7, 32'hFFFFFFFF, 1, 32); chk("pin_slt", m.lo, 32'h1);
    m = model(4'd8, 32'hFFFFFFFF, 1, 32); chk("pin_sltu", m.lo, 32'h0);
    m = model(4'd11, 32'h80000000, 4, 32); chk("pin_sra", m.lo, 32'hF8000000);
    m = model(4'd10, 32'h80000000, 4, 32); chk("pin_srl", m.lo, 32'h08000000);
    m = model(4'd4, 32'h1234, 0, 32); chk("pin_div0", {m.dz, m.hi, m.lo}, {1'b1, 32'h1234, 32'hFFFFFFFF});
    m = model(4'd3, 8'hFF, 8'hFF, 8); chk("pin_mul8", {m.hi, m.lo}, {32'hFE, 32'h01});

    repeat (2) @(negedge clock);
    chk("rst_saida", saida, 32'h0);
    chk("rst_zero", zero, 1'b1);
    chk("rst_flags", {saidaHi, overflow, divZero, ocupado, pronto}, 36'h0);
    reset_n = 1'b1;
    started = 1'b1;
    @(negedge clock);

    // Directed cases.
    issue(4'd2, 32'h7FFFFFFF, 32'h1, 1'b0);
    issue(4'd6, 32'd5, 32'd5, 1'b0);
    issue(4'd7, 32'hFFFFFFFF, 32'h1, 1'b0);
    issue(4'd8, 32'hFFFFFFFF, 32'h1, 1'b0);
    issue(4'd11, 32'h80000000, 32'd4, 1'b0);
    issue(4'd10, 32'h80000000, 32'd4, 1'b0);
    issue(4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    repeat (5) @(negedge clock);
    inicio = 1'b1; ctrl = 4'd2; a = 32'h11; b = 32'h22;   // ignored while busy
    @(negedge clock);
    inicio = 1'b0;
    issue(4'd4, 32'd100, 32'd7, 1'b0);
    issue(4'd4, 32'h1234, 32'h0, 1'b0);
    drain();

    // inicio held high: one completion every other cycle.
    for (int i = 0; i < 5; i++) issue(4'd2, rval(), rval(), 1'b1);
    inicio = 1'b0;
    drain();

    do_reset("rst_idle");

    issue(4'd1, 32'hA5A50000, 32'h00005A5A, 1'b0);
    issue(4'd3, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    while (cyc < last_acc + 22) @(negedge clock);   // iteration counter now at 10
    do_reset("rst_mid");
    repeat (40) @(negedge clock);

    // Randomized mix; operands and inicio are disturbed while each op is in flight.
    for (int i = 0; i < 60; i++) begin
      issue(ops[$urandom_range(15)], rval(), ($urandom_range(7) == 0) ? 32'h0 : rval(), 1'b0);
      a = $urandom(); b = $urandom(); ctrl = 4'($urandom_range(15));
      inicio = ($urandom_range(1) == 1);
      @(negedge clock);
      inicio = 1'b0;
    end
    drain();

    run8(4'd3, 8'hFF, 8'hFF);
    for (int i = 0; i < 8; i++)
      run8(($urandom_range(1) == 1) ? 4'd3 : 4'd4, 8'($urandom()), 8'($urandom_range(3) == 0 ? 0 : $urandom()));

    started = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
